// File: rtl/spectro_pkg.sv
// -----------------------------------------------------------------------------
// spectro_pkg
// Shared constants and types for the spectrogram serial frame.
//   WORD_W     : bits per slot, sent MSB first, one bit per clock
//   N_SLOTS    : slots per frame (slot 0 = RTC timestamp, 1..15 = filter channels)
//   SEL_W      : width of the slot index
//   FIFO_DEPTH : default depth of the receiver output FIFO (power of 2)
//   rx_state_e : receiver FSM state encoding
//   slot_word_t: one rebuilt word tagged with its slot index
// -----------------------------------------------------------------------------
package spectro_pkg;

  localparam int WORD_W     = 12;
  localparam int N_SLOTS    = 16;
  localparam int SEL_W      = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = $clog2(WORD_W);

  localparam logic [SEL_W-1:0] SLOT_RTC  = '0;
  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_SLOTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WAIT_END
  } rx_state_e;

  typedef struct packed {
    logic [SEL_W-1:0]  chan;
    logic [WORD_W-1:0] data;
  } slot_word_t;

endpackage

// File: rtl/spectro_frame_receiver_if.sv
// -----------------------------------------------------------------------------
// spectro_frame_receiver_if
// Bundles the serial link inputs, the tagged valid/ready word stream and the
// frame status outputs of the receiver.
//   master : transmitter/consumer side (drives link and m_ready)
//   slave  : receiver side (samples link, drives stream and status)
// -----------------------------------------------------------------------------
interface spectro_frame_receiver_if;

  logic                             sdata;
  logic                             sl;
  logic [spectro_pkg::SEL_W-1:0]    sel;
  logic                             frame_rst;

  logic                             m_valid;
  logic                             m_ready;
  logic [spectro_pkg::WORD_W-1:0]   m_data;
  logic [spectro_pkg::SEL_W-1:0]    m_chan;
  logic                             m_last;

  logic                             frame_done;
  logic                             err_seq;
  logic                             err_len;
  logic                             err_ovr;

  modport master (
    output sdata, sl, sel, frame_rst, m_ready,
    input  m_valid, m_data, m_chan, m_last, frame_done, err_seq, err_len, err_ovr
  );

  modport slave (
    input  sdata, sl, sel, frame_rst, m_ready,
    output m_valid, m_data, m_chan, m_last, frame_done, err_seq, err_len, err_ovr
  );

endinterface

// File: rtl/spectro_frame_receiver_slot_fifo.sv
// -----------------------------------------------------------------------------
// slot_fifo
// Synchronous FIFO, DEPTH a power of 2. A push into a full FIFO is accepted
// when a pop happens in the same cycle. The head is presented directly from
// storage and forced to zero while empty.
//   clk, rst_n : clock, async active-low reset
//   push_i     : write din_i (ignored when full without a simultaneous pop)
//   din_i      : write data
//   pop_i      : remove the head (ignored when empty)
//   dout_o     : current head, zero when empty
//   full_o     : DEPTH entries stored
//   empty_o    : no entries stored
// -----------------------------------------------------------------------------
module slot_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  // NOTE: the storage array has no reset; only the pointers and count do.
  // A reset therefore empties the FIFO, and the gated head keeps the outputs
  // at zero until real data is written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/spectro_frame_receiver.sv
// -----------------------------------------------------------------------------
// spectro_frame_receiver
// Deserializes the spectrogram frame: samples sdata under the slot strobe,
// rebuilds one WORD_W-bit word per slot, checks slot order and lengths, and
// queues {slot index, word} into an output FIFO read as a valid/ready stream.
//   clk, rst_n : clock, async active-low reset
//   bus.slave  : sdata/sl/sel/frame_rst in; m_valid/m_data/m_chan/m_last out
//                with m_ready in; frame_done pulse; sticky err_seq/err_len/err_ovr
// -----------------------------------------------------------------------------
module spectro_frame_receiver
  import spectro_pkg::*;
#(
  parameter int FIFO_DEPTH = spectro_pkg::FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  spectro_frame_receiver_if.slave  bus
);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SEL_W-1:0]  exp_chan_q, exp_chan_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              err_seq_q, err_seq_d;
  logic              err_len_q, err_len_d;
  logic              err_ovr_q, err_ovr_d;
  logic              frame_done_q, frame_done_d;
  logic              wr_pend_q, wr_pend_d;
  slot_word_t        wr_word_q, wr_word_d;

  logic              frame_start;
  logic [WORD_W-1:0] shifted;
  logic              fifo_full, fifo_empty, fifo_pop, ovr_drop;
  slot_word_t        head;

  assign shifted  = {shreg_q[WORD_W-2:0], bus.sdata};
  assign fifo_pop = ~fifo_empty & bus.m_ready;
  // A staged word that meets a full FIFO with no pop is lost.
  assign ovr_drop = wr_pend_q & fifo_full & ~fifo_pop;

  // NOTE: every variable gets its default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    exp_chan_d   = exp_chan_q;
    shreg_d      = shreg_q;
    err_seq_d    = err_seq_q;
    err_len_d    = err_len_q;
    err_ovr_d    = err_ovr_q;
    frame_done_d = 1'b0;
    wr_pend_d    = 1'b0;
    wr_word_d    = wr_word_q;
    frame_start  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.frame_rst)            err_len_d   = 1'b1;
        else if (bus.sl) begin
          if (bus.sel == SLOT_RTC)    frame_start = 1'b1;
          else                        err_seq_d   = 1'b1;
        end
      end

      ST_SHIFT: begin
        if (bus.frame_rst) begin
          err_len_d = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_IDLE;
        end else if (bit_cnt_q != '0) begin
          if (bus.sl) begin
            // Short slot: drop the partial word and restart on this strobe.
            err_len_d  = 1'b1;
            shreg_d    = WORD_W'(bus.sdata);
            bit_cnt_d  = CNT_W'(1);
            exp_chan_d = bus.sel;
          end else begin
            shreg_d = shifted;
            if (bit_cnt_q == CNT_W'(WORD_W - 1)) begin
              // Stage the word so the FIFO write lands one edge later.
              bit_cnt_d = '0;
              wr_pend_d = 1'b1;
              wr_word_d = '{chan: exp_chan_q, data: shifted};
              if (exp_chan_q == LAST_SLOT) state_d    = ST_WAIT_END;
              else                         exp_chan_d = exp_chan_q + SEL_W'(1);
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end else if (bus.sl) begin
          if (bus.sel != exp_chan_q) begin
            err_seq_d  = 1'b1;
            exp_chan_d = bus.sel;
          end
          shreg_d   = WORD_W'(bus.sdata);
          bit_cnt_d = CNT_W'(1);
        end else begin
          err_len_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_WAIT_END: begin
        if (bus.frame_rst) begin
          frame_done_d = ~(err_seq_q | err_len_q | err_ovr_q | ovr_drop);
          state_d      = ST_IDLE;
        end else if (bus.sl) begin
          if (bus.sel == SLOT_RTC) begin
            frame_start = 1'b1;
          end else begin
            err_seq_d = 1'b1;
            err_len_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (frame_start) begin
      err_seq_d  = 1'b0;
      err_len_d  = 1'b0;
      err_ovr_d  = 1'b0;
      shreg_d    = WORD_W'(bus.sdata);
      bit_cnt_d  = CNT_W'(1);
      exp_chan_d = SLOT_RTC;
      state_d    = ST_SHIFT;
      // A frame started without the closing frame_rst is reported on the new frame.
      if (state_q == ST_WAIT_END) err_len_d = 1'b1;
    end
    if (ovr_drop) err_ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      exp_chan_q   <= '0;
      shreg_q      <= '0;
      err_seq_q    <= 1'b0;
      err_len_q    <= 1'b0;
      err_ovr_q    <= 1'b0;
      frame_done_q <= 1'b0;
      wr_pend_q    <= 1'b0;
      wr_word_q    <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      exp_chan_q   <= exp_chan_d;
      shreg_q      <= shreg_d;
      err_seq_q    <= err_seq_d;
      err_len_q    <= err_len_d;
      err_ovr_q    <= err_ovr_d;
      frame_done_q <= frame_done_d;
      wr_pend_q    <= wr_pend_d;
      wr_word_q    <= wr_word_d;
    end
  end

  slot_fifo #(
    .WIDTH ($bits(slot_word_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (wr_pend_q),
    .din_i   (wr_word_q),
    .pop_i   (fifo_pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.m_valid    = ~fifo_empty;
  assign bus.m_data     = head.data;
  assign bus.m_chan     = head.chan;
  assign bus.m_last     = ~fifo_empty & (head.chan == LAST_SLOT);
  assign bus.frame_done = frame_done_q;
  assign bus.err_seq    = err_seq_q;
  assign bus.err_len    = err_len_q;
  assign bus.err_ovr    = err_ovr_q;

endmodule

// File: tb/tb_spectro_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_spectro_frame_receiver
// Directed frames for spectro_frame_receiver. Stimulus pushes each expected
// {chan, word} into a queue; a monitor pops and compares on every accepted
// handshake and counts frame_done pulses.
// -----------------------------------------------------------------------------
module tb_spectro_frame_receiver;

  typedef struct packed {
    logic [3:0]  chan;
    logic [11:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spectro_frame_receiver_if bus ();

  spectro_frame_receiver #(.FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare the head on every accepted transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (bus.frame_done === 1'b1) done_cnt++;
        if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected actual chan=%0d data=0x%0h expected no word",
                     bus.m_chan, bus.m_data);
          end else begin
            mon_e = exp_q.pop_front();
            check("m_data", 32'(bus.m_data), 32'(mon_e.data));
            check("m_chan", 32'(bus.m_chan), 32'(mon_e.chan));
            check("m_last", 32'(bus.m_last), 32'(mon_e.chan == 4'd15));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send_bit(input logic b, input logic s, input logic [3:0] sel);
    bus.sdata = b;
    bus.sl    = s;
    bus.sel   = sel;
    @(posedge clk); #1;
  endtask

  task automatic send_slot(input logic [11:0] w, input logic [3:0] sel, input int nbits);
    for (int i = 0; i < nbits; i++) send_bit(w[11-i], (i == 0), sel);
  endtask

  task automatic idle(input int n);
    bus.sl = 1'b0; bus.sdata = 1'b0; bus.frame_rst = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame_rst();
    bus.sl = 1'b0; bus.sdata = 1'b0; bus.frame_rst = 1'b1;
    @(posedge clk); #1;
    bus.frame_rst = 1'b0;
  endtask

  task automatic expect_word(input int chan, input logic [11:0] data);
    exp_q.push_back(exp_t'({4'(chan), data}));
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
    check({name, "_drain_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_flags(input string name, input logic s, input logic l, input logic o);
    check({name, "_err_seq"}, 32'(bus.err_seq), 32'(s));
    check({name, "_err_len"}, 32'(bus.err_len), 32'(l));
    check({name, "_err_ovr"}, 32'(bus.err_ovr), 32'(o));
  endtask

  task automatic nominal_frame(input string name);
    done_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      expect_word(k, 12'(12'hA00 + k));
      send_slot(12'(12'hA00 + k), 4'(k), 12);
    end
    send_frame_rst();
    idle(3);
    drain(name);
    check({name, "_frame_done"}, 32'(done_cnt), 32'd1);
    check_flags(name, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_m_valid"},    32'(bus.m_valid),    32'd0);
    check({name, "_m_data"},     32'(bus.m_data),     32'd0);
    check({name, "_m_chan"},     32'(bus.m_chan),     32'd0);
    check({name, "_m_last"},     32'(bus.m_last),     32'd0);
    check({name, "_frame_done"}, 32'(bus.frame_done), 32'd0);
    check_flags(name, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.sdata = 1'b0; bus.sl = 1'b0; bus.sel = '0;
    bus.frame_rst = 1'b0; bus.m_ready = 1'b0;

    // Reset state.
    #3;
    check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Nominal frame, consumer always ready.
    bus.m_ready = 1'b1;
    nominal_frame("nominal");

    // Slot 5 carries sel=6; the following slot 6 realigns.
    done_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      int s;
      s = (k == 5) ? 6 : k;
      expect_word(s, 12'(12'hA00 + k));
      send_slot(12'(12'hA00 + k), 4'(s), 12);
    end
    send_frame_rst();
    idle(3);
    drain("seq");
    check("seq_frame_done", 32'(done_cnt), 32'd0);
    check_flags("seq", 1'b1, 1'b0, 1'b0);

    // Short slot 3: strobe returns after 7 bits; frame start clears err_seq.
    done_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 3) send_slot(12'h5A5, 4'd3, 7);
      expect_word(k, 12'(12'hA00 + k));
      send_slot(12'(12'hA00 + k), 4'(k), 12);
      if (k == 0) check("start_clears_err_seq", 32'(bus.err_seq), 32'd0);
    end
    send_frame_rst();
    idle(3);
    drain("short");
    check("short_frame_done", 32'(done_cnt), 32'd0);
    check_flags("short", 1'b0, 1'b1, 1'b0);

    // Consumer stalled for the whole frame: only words 0..3 survive.
    bus.m_ready = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (k < 4) expect_word(k, 12'(12'hA00 + k));
      send_slot(12'(12'hA00 + k), 4'(k), 12);
    end
    send_frame_rst();
    idle(3);
    check("ovr_head_valid", 32'(bus.m_valid), 32'd1);
    check("ovr_head_data",  32'(bus.m_data),  32'hA00);
    idle(2);
    check("ovr_head_stable", 32'(bus.m_data), 32'hA00);
    check("ovr_frame_done", 32'(done_cnt), 32'd0);
    check_flags("ovr", 1'b0, 1'b0, 1'b1);
    bus.m_ready = 1'b1;
    drain("ovr");

    // FIFO full when slot 4 lands, with a pop in that same cycle: nothing lost.
    bus.m_ready = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      expect_word(k, 12'(12'hA00 + k));
      send_slot(12'(12'hA00 + k), 4'(k), 12);
      if (k == 4) bus.m_ready = 1'b1;
    end
    send_frame_rst();
    idle(3);
    drain("fullpop");
    check("fullpop_frame_done", 32'(done_cnt), 32'd1);
    check_flags("fullpop", 1'b0, 1'b0, 1'b0);

    // frame_rst in the middle of slot 9.
    done_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      expect_word(k, 12'(12'hA00 + k));
      send_slot(12'(12'hA00 + k), 4'(k), 12);
    end
    send_slot(12'hA09, 4'd9, 5);
    send_frame_rst();
    idle(3);
    drain("early_rst");
    check("early_rst_frame_done", 32'(done_cnt), 32'd0);
    check_flags("early_rst", 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-slot with data held and an error flag set.
    bus.m_ready = 1'b0;
    send_slot(12'hA00, 4'd0, 12);
    send_slot(12'hA01, 4'd2, 12);
    send_slot(12'hA02, 4'd2, 5);
    check("pre_rst_m_valid", 32'(bus.m_valid), 32'd1);
    check("pre_rst_err_seq", 32'(bus.err_seq), 32'd1);
    #3 rst_n = 1'b0;
    #1 check_outputs_zero("async_rst");
    idle(2);
    rst_n = 1'b1;
    idle(2);
    bus.m_ready = 1'b1;
    nominal_frame("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
